// File: rtl/mips32_fetch_queue.sv
// rtl/mips32_fetch_queue.sv - MIPS32 instruction fetch front end with buffered IR/NPC queue
//
// Purpose: issues word reads to a synchronous instruction memory, buffers the
// returned words together with their next-PC, and hands them to the ID stage
// over a valid/ready handshake. Handles taken-branch redirects and stops
// fetching after an HLT opcode has been captured.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   imem_en      read strobe, data returns on imem_rdata one cycle later
//   imem_addr    read address (the PC register)
//   imem_rdata   read data, valid the cycle after imem_en
//   redirect     taken-branch pulse
//   redirect_pc  branch target
//   out_valid    queue head valid
//   out_ready    ID stage accepts the head
//   out_ir       head instruction word (0 when empty)
//   out_npc      head PC+1, zero-extended and not truncated (0 when empty)
//   halt_seen    an HLT has been captured, fetch is stopped
//   occupancy    current queue entry count
module mips32_fetch_queue #(
  parameter int              AW       = 10,
  parameter int              DEPTH    = 4,
  parameter logic [AW-1:0]   RESET_PC = '0,
  parameter logic [5:0]      HLT_OP   = 6'b111111
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_en,
  output logic [AW-1:0]              imem_addr,
  input  logic [31:0]                imem_rdata,
  input  logic                       redirect,
  input  logic [AW-1:0]              redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_ir,
  output logic [31:0]                out_npc,
  output logic                       halt_seen,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_V = (CW+1)'(DEPTH);

  logic [AW-1:0] pc;
  logic [AW-1:0] inflight_pc;
  logic          inflight;
  logic          halt_q;

  logic [31:0]   ir_mem  [DEPTH];
  logic [31:0]   npc_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic [CW:0]   pending;
  logic          push;
  logic          pop;
  logic          is_hlt;
  logic [31:0]   npc_in;

  // A slot is reserved for every outstanding read, so a returning word can
  // always be pushed without any back-pressure on the memory side.
  assign pending = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign imem_en = !rst && !redirect && !halt_q && (pending < DEPTH_V);
  assign imem_addr = pc;

  // Redirect squashes the in-flight response and voids any pop that cycle.
  assign push   = inflight && !redirect && !halt_q;
  assign pop    = out_valid && out_ready && !redirect;
  assign is_hlt = (imem_rdata[31:26] == HLT_OP);
  // Computed in 32 bits so the word at 2^AW-1 reports NPC 2^AW, not 0.
  assign npc_in = 32'(inflight_pc) + 32'd1;

  assign out_valid = (count != '0);
  assign out_ir    = out_valid ? ir_mem[rd_ptr]  : 32'd0;
  assign out_npc   = out_valid ? npc_mem[rd_ptr] : 32'd0;
  assign halt_seen = halt_q;
  assign occupancy = count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      inflight_pc <= '0;
      inflight    <= 1'b0;
      halt_q      <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else if (redirect) begin
      pc       <= redirect_pc;
      inflight <= 1'b0;
      halt_q   <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (imem_en) begin
        inflight_pc <= pc;
        pc          <= pc + AW'(1);
        inflight    <= 1'b1;
      end else begin
        inflight    <= 1'b0;
      end

      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
        if (is_hlt) begin
          halt_q <= 1'b1;
        end
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end

      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset; occupancy alone qualifies it.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      ir_mem[wr_ptr]  <= imem_rdata;
      npc_mem[wr_ptr] <= npc_in;
    end
  end

endmodule

// File: doc/mips32_fetch_queue.md
Name: mips32_fetch_queue

Overview:
- Instruction-fetch front end for the MIPS32 pipeline.
- Issues word-addressed reads to a synchronous instruction memory and buffers returned words with their next-PC in a small FIFO.
- Presents the buffered words to the ID stage over a valid/ready handshake.
- Handles branch redirects (flushes buffer and any in-flight read) and stops fetching once an HLT opcode has been fetched.

Parameters:
- AW, 10, instruction memory address width (word addresses; PC increments by 1).
- DEPTH, 4, FIFO entries; power of 2, minimum 2; 3 or more is required for 1 instruction/cycle throughput.
- RESET_PC, 0, PC value loaded on reset.
- HLT_OP, 6'b111111, opcode in bits [31:26] that stops fetch.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_en  out  1  read strobe; data is returned on imem_rdata one cycle later.
- imem_addr  out  AW  read address; equals the internal PC register.
- imem_rdata  in  32  read data, valid in the cycle after imem_en=1.
- redirect  in  1  taken-branch redirect, single-cycle pulse.
- redirect_pc  in  AW  branch target.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  ID stage accepts the head entry.
- out_ir  out  32  head instruction word.
- out_npc  out  32  head PC+1, zero-extended.
- halt_seen  out  1  an HLT has been captured; fetch is stopped.
- occupancy  out  $clog2(DEPTH)+1  current FIFO entry count.

Behaviour:
- Reset values (async, rst=1):
  - PC=RESET_PC; FIFO empty; occupancy=0; out_valid=0.
  - out_ir=0; out_npc=0; inflight=0; halt_seen=0; imem_en=0.
- Issue rule: imem_en=1 when !rst, !redirect, !halt_seen and occupancy+inflight < DEPTH.
  - On issue: inflight_pc<=PC, PC<=PC+1 (mod 2^AW), inflight<=1; otherwise inflight<=0.
- Capture: in a cycle with inflight=1, not squashed and !halt_seen, imem_rdata with NPC=inflight_pc+1 is pushed at the clock edge.
  - If imem_rdata[31:26]==HLT_OP, the word is pushed and halt_seen<=1 at the same edge.
- Responses arriving while halt_seen=1 are discarded. This covers the word fetched in the cycle after the HLT.
- Pop: head is removed at the edge when out_valid && out_ready. Pop and push may occur in the same cycle; occupancy is unchanged in that case.
- Overflow cannot occur: the issue rule reserves a slot for every in-flight read. A push into a full FIFO is a design error; the bench asserts it never happens.
- Latency: first issue is in the first cycle after rst deasserts. The word is captured at the end of the next cycle, and out_valid is seen 2 cycles after issue.
- Throughput: with out_ready held at 1 and DEPTH≥3, one word per cycle in steady state.
- Redirect (cycle T):
  - At the T edge: FIFO emptied, in-flight read squashed (its data is not pushed), PC<=redirect_pc, halt_seen<=0.
  - imem_en=0 during T.
  - The target is issued at T+1 and out_valid is seen at T+3.
  - Any pop handshake during T is void; the consumer discards its ID-stage state on redirect.
- Redirect has priority over push, pop, halt detection and the issue rule.
- Reset mid-operation: immediate return to reset values. Any memory response still pending is ignored.
- PC wrap: RESET_PC or redirect to 2^AW−1 fetches that word, then wraps to address 0. out_npc = 2^AW zero-extended, i.e. not truncated.

Test Plan:
1. Reset with mem[0..3]={ADD,SUB,AND,OR}, out_ready=1 → imem_addr 0,1,2,3 on consecutive cycles; out_ir sequence matches, out_npc=1,2,3,4; out_valid first high 2 cycles after reset release.
2. out_ready=0 for 10 cycles → occupancy saturates at 4; imem_en low while occupancy+inflight=4. Release → 4 words drain in order with no loss or duplicate, then streaming resumes at address 4.
3. mem[5]=HLT (0xFC000000), mem[6]=ADD → word at 5 delivered with out_npc=6; halt_seen=1; word 6 never appears; imem_en stays 0.
4. Redirect to 20 while occupancy=3 and a read is in flight → occupancy=0 next cycle; squashed word is never output; imem_addr=20 at T+1; out_ir=mem[20] with out_npc=21 at T+3.
5. Redirect while halt_seen=1 → halt_seen cleared; fetch restarts at redirect_pc.
6. Assert rst while occupancy=2 and a read is in flight → out_valid=0 and occupancy=0 immediately; after release, fetch restarts at RESET_PC.
